uart_cmd_tx: RTL and testbench

- Host-bound byte path: the reverse of the coe_data/coe_done byte-capture path into the Nios.
- Firmware writes bytes through a 32-bit output PIO register (o_reg32_N_export). The block queues them in a small FIFO and serialises them 8N1 on a dedicated UART TX pin.
- Status returns to firmware through a 16-bit input PIO register (i_reg16_N_export).
- Sits in the top level beside the NiosBase instance, on the same clock.

---
 rtl/uart_cmd_tx_pkg.sv | 32 +++
 rtl/uart_cmd_tx_if.sv | 28 ++
 rtl/uart_tx_fifo.sv | 70 +++++++
 rtl/uart_cmd_tx.sv | 201 ++++++++++++++++++++
 tb/tb_uart_cmd_tx.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : monitorx_uart_pkg
// Description : Shared constants and types for the uart_cmd_tx byte path:
//               command/status bit positions and the TX state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package monitorx_uart_pkg;

  // Command word (from the o_reg32 PIO) bit positions
  localparam int CMD_DATA_LSB    = 0;
  localparam int CMD_DATA_MSB    = 7;
  localparam int CMD_WR_TOG      = 8;
  localparam int CMD_OVF_CLR_TOG = 9;

  // Status word (to the i_reg16 PIO) bit positions
  localparam int ST_COUNT_MSB = 4;
  localparam int ST_FULL      = 8;
  localparam int ST_EMPTY     = 9;
  localparam int ST_BUSY      = 10;
  localparam int ST_OVF       = 11;

  // Serialiser states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_tx_if
// Description : Firmware-facing command/status bundle plus the serial pins.
//               master = PIO/firmware side, slave = uart_cmd_tx.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_tx_if;
  logic [31:0] cmd_word;
  logic [15:0] status_word;
  logic        uart_txd;
  logic        tx_done;

  modport master (
    output cmd_word,
    input  status_word,
    input  uart_txd,
    input  tx_done
  );

  modport slave (
    input  cmd_word,
    output status_word,
    output uart_txd,
    output tx_done
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous first-word-fall-through byte FIFO. A push while
//               full is dropped even if a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  wire logic             clk_i,
  input  wire logic             rst_ni,
  input  wire logic             push_i,
  input  wire logic [7:0]       data_i,
  input  wire logic             pop_i,
  output logic      [7:0]       data_o,
  output logic      [CNT_W-1:0] count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             w_wr;
  logic             w_rd;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign w_wr    = push_i & ~full_o;
  assign w_rd    = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array: written on accepted pushes only, no reset needed
  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Occupancy: simultaneous accepted push and pop leave the count unchanged
  always_comb begin
    count_d = count_q;
    case ({w_wr, w_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers and count; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_tx
// Description : Host-bound byte path. Firmware toggles command bits to push
//               bytes into a FIFO; bytes are serialised 8N1 on uart_txd
//               back-to-back, with status reported through status_word.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_tx
  import monitorx_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input wire logic     clk_clk,
  input wire logic     reset_reset_n,
  uart_cmd_tx_if.slave bus
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [31:0]      cmd_q;
  logic             tog8_q;
  logic             tog9_q;
  logic             w_push;
  logic             w_clr;
  logic             w_unused_cmd;

  logic [7:0]       w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;

  tx_state_t        state_q;
  tx_state_t        state_d;
  logic [BAUD_W-1:0] baud_q;
  logic [BAUD_W-1:0] baud_d;
  logic [2:0]       bit_q;
  logic [2:0]       bit_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic             w_tick;
  logic             txd_q;
  logic             txd_d;
  logic             done_q;
  logic             done_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [15:0]      w_status;

  // Write and clear requests are edges on the toggle bits of the captured word
  assign w_push       = cmd_q[CMD_WR_TOG] ^ tog8_q;
  assign w_clr        = cmd_q[CMD_OVF_CLR_TOG] ^ tog9_q;
  assign w_unused_cmd = ^cmd_q[31:CMD_OVF_CLR_TOG+1];
  assign w_tick       = (baud_q == BAUD_LAST);

  // Capture the PIO word and keep one cycle of toggle history
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cmd_q  <= '0;
      tog8_q <= 1'b0;
      tog9_q <= 1'b0;
    end else begin
      cmd_q  <= bus.cmd_word;
      tog8_q <= cmd_q[CMD_WR_TOG];
      tog9_q <= cmd_q[CMD_OVF_CLR_TOG];
    end
  end

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_clk),
    .rst_ni  (reset_reset_n),
    .push_i  (w_push),
    .data_i  (cmd_q[CMD_DATA_MSB:CMD_DATA_LSB]),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Sticky overflow: a dropped push wins over a simultaneous clear
  always_comb begin
    ovf_d = ovf_q;
    if (w_push && w_full) begin
      ovf_d = 1'b1;
    end else if (w_clr) begin
      ovf_d = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a pop at stop-bit end chains straight into the next start
  always_comb begin
    state_d = state_q;
    w_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (w_tick) state_d = DATA;
      end
      DATA: begin
        if (w_tick && (bit_q == 3'd7)) state_d = STOP;
      end
      STOP: begin
        if (w_tick) begin
          if (!w_empty) begin
            w_pop   = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Baud counter, bit index and shift register next values
  always_comb begin
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    if ((state_q == IDLE) || w_tick) begin
      baud_d = '0;
    end
    if ((state_q == DATA) && w_tick) begin
      shift_d = {1'b0, shift_q[7:1]};
      bit_d   = bit_q + 1'b1;
    end else if (state_q != DATA) begin
      bit_d = '0;
    end
    if (w_pop) begin
      shift_d = w_head;
    end
  end

  // FSM outputs, decoded from next state so the registered pin has no lag
  always_comb begin
    txd_d  = 1'b1;
    done_d = (state_q == STOP) && w_tick;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // Datapath and output registers; reset forces the line idle immediately
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status word assembly; unused bits read as zero
  always_comb begin
    w_status                 = '0;
    w_status[ST_COUNT_MSB:0] = (ST_COUNT_MSB + 1)'(w_count);
    w_status[ST_FULL]        = w_full;
    w_status[ST_EMPTY]       = w_empty;
    w_status[ST_BUSY]        = (state_q != IDLE);
    w_status[ST_OVF]         = ovf_q;
  end

  assign bus.status_word = w_status;
  assign bus.uart_txd    = txd_q;
  assign bus.tx_done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_tx
// Description : Directed self-checking bench for uart_cmd_tx with
//               CLKS_PER_BIT=4 and FIFO_DEPTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic       tog8 = 1'b0;
  logic       tog9 = 1'b0;
  logic [7:0] cur_data = 8'h00;

  uart_cmd_tx_if bus ();

  uart_cmd_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    tog8         = ~tog8;
    cur_data     = b;
    bus.cmd_word = {22'd0, tog9, tog8, b};
  endtask

  task automatic clear_ovf();
    tog9         = ~tog9;
    bus.cmd_word = {22'd0, tog9, tog8, cur_data};
  endtask

  // Checks 40 consecutive samples of one frame, starting at its first start-bit sample
  task automatic check_frame(input logic [7:0] b, input logic done_first);
    for (int k = 0; k < 10 * CPB; k++) begin
      logic exp_txd;
      if (k < CPB)            exp_txd = 1'b0;
      else if (k < 9 * CPB)   exp_txd = b[(k - CPB) / CPB];
      else                    exp_txd = 1'b1;
      chk($sformatf("frame_%02h_txd_k%0d", b, k), 32'(bus.uart_txd), 32'(exp_txd));
      chk($sformatf("frame_%02h_done_k%0d", b, k), 32'(bus.tx_done),
          (k == 0) ? 32'(done_first) : 32'd0);
      tick(1);
    end
  endtask

  initial begin
    int budget;
    bus.cmd_word = 32'd0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("in_reset_status", 32'(bus.status_word), 32'h0200);
    chk("in_reset_txd", 32'(bus.uart_txd), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      chk("idle_status", 32'(bus.status_word), 32'h0200);
      chk("idle_txd", 32'(bus.uart_txd), 32'd1);
      chk("idle_done", 32'(bus.tx_done), 32'd0);
    end

    // Single byte 0x55: push latency, then one frame
    write_byte(8'h55);
    chk("cmd_word_155", bus.cmd_word, 32'h0000_0155);
    tick(1);
    chk("single_n1_status", 32'(bus.status_word), 32'h0200);
    tick(1);
    chk("single_n2_status", 32'(bus.status_word), 32'h0001);
    chk("single_n2_txd", 32'(bus.uart_txd), 32'd1);
    tick(1);
    chk("single_start_status", 32'(bus.status_word), 32'h0600);
    check_frame(8'h55, 1'b0);
    chk("single_end_done", 32'(bus.tx_done), 32'd1);
    chk("single_end_txd", 32'(bus.uart_txd), 32'd1);
    chk("single_end_status", 32'(bus.status_word), 32'h0200);
    tick(1);
    chk("single_after_done", 32'(bus.tx_done), 32'd0);

    // Three back-to-back bytes
    write_byte(8'hA5);
    tick(1);
    write_byte(8'h0F);
    tick(1);
    write_byte(8'hFF);
    tick(1);
    check_frame(8'hA5, 1'b0);
    check_frame(8'h0F, 1'b1);
    check_frame(8'hFF, 1'b1);
    chk("burst_end_done", 32'(bus.tx_done), 32'd1);
    chk("burst_end_txd", 32'(bus.uart_txd), 32'd1);
    chk("burst_end_status", 32'(bus.status_word), 32'h0200);
    tick(1);

    // Fill past full while the first byte is on the line, then clear overflow
    write_byte(8'h10);
    tick(3);
    chk("fill_first_start_txd", 32'(bus.uart_txd), 32'd0);
    for (int i = 0; i < 17; i++) begin
      write_byte(8'(8'h20 + i));
      tick(1);
    end
    tick(2);
    chk("full_status", 32'(bus.status_word), 32'h0D10);
    clear_ovf();
    tick(3);
    chk("ovf_clear_status", 32'(bus.status_word), 32'h0510);
    budget = 100;
    while ((bus.tx_done !== 1'b1) && (budget > 0)) begin
      tick(1);
      budget--;
    end
    chk("fill_first_done_seen", 32'(bus.tx_done), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check_frame(8'(8'h20 + i), 1'b1);
    end
    chk("drain_end_done", 32'(bus.tx_done), 32'd1);
    chk("drain_end_status", 32'(bus.status_word), 32'h0200);
    tick(5);
    chk("no_17th_txd", 32'(bus.uart_txd), 32'd1);
    chk("no_17th_status", 32'(bus.status_word), 32'h0200);

    // Data change without a write toggle pushes nothing
    bus.cmd_word = {22'd0, tog9, tog8, 8'hC3};
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("notog_status", 32'(bus.status_word), 32'h0200);
      chk("notog_txd", 32'(bus.uart_txd), 32'd1);
    end

    // Reset in the middle of data bit 3, with one byte still queued
    write_byte(8'hF0);
    tick(1);
    write_byte(8'h33);
    tick(2);
    chk("rst_frame_start_txd", 32'(bus.uart_txd), 32'd0);
    tick(4 + 3 * CPB + 1);
    chk("rst_bit3_txd", 32'(bus.uart_txd), 32'd0);
    chk("rst_bit3_status", 32'(bus.status_word), 32'h0401);
    #2;
    rst_n        = 1'b0;
    tog8         = 1'b0;
    tog9         = 1'b0;
    cur_data     = 8'h00;
    bus.cmd_word = 32'd0;
    #1;
    chk("rst_async_txd", 32'(bus.uart_txd), 32'd1);
    chk("rst_async_status", 32'(bus.status_word), 32'h0200);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      chk("post_rst_status", 32'(bus.status_word), 32'h0200);
      chk("post_rst_txd", 32'(bus.uart_txd), 32'd1);
      chk("post_rst_done", 32'(bus.tx_done), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
